// File: rtl/regfile_writeback_if.sv
// regfile_writeback_if: bundle of ALU, load issue/response, hazard-check and regfile write signals
//   master: upstream pipeline side (drives results, loads, decode checks; observes readies, stall, write)
//   slave : regfile_writeback side
//   WB_FORWARD_EN adds fwd_rs_hit / fwd_rt_hit
interface regfile_writeback_if #(parameter int DATA_W = 32);
   logic              alu_valid;
   logic [4:0]        alu_rd;
   logic [DATA_W-1:0] alu_data;
   logic              ld_issue_valid;
   logic [4:0]        ld_issue_rd;
   logic              ld_issue_ready;
   logic              ld_resp_valid;
   logic [DATA_W-1:0] ld_resp_data;
   logic              ld_resp_ready;
   logic [4:0]        chk_rs;
   logic [4:0]        chk_rt;
   logic [4:0]        chk_rd;
   logic              stall;
   logic              we;
   logic [4:0]        rd_addr;
   logic [DATA_W-1:0] rd_data;
`ifdef WB_FORWARD_EN
   logic              fwd_rs_hit;
   logic              fwd_rt_hit;
`endif
   modport master (
`ifdef WB_FORWARD_EN
      input  fwd_rs_hit, fwd_rt_hit,
`endif
      output alu_valid, alu_rd, alu_data, ld_issue_valid, ld_issue_rd, ld_resp_valid, ld_resp_data,
             chk_rs, chk_rt, chk_rd,
      input  ld_issue_ready, ld_resp_ready, stall, we, rd_addr, rd_data
   );
   modport slave (
`ifdef WB_FORWARD_EN
      output fwd_rs_hit, fwd_rt_hit,
`endif
      input  alu_valid, alu_rd, alu_data, ld_issue_valid, ld_issue_rd, ld_resp_valid, ld_resp_data,
             chk_rs, chk_rt, chk_rd,
      output ld_issue_ready, ld_resp_ready, stall, we, rd_addr, rd_data
   );
endinterface

// File: rtl/regfile_writeback.sv
// regfile_writeback: single-port regfile write arbiter with load-destination scoreboard
//   clk, reset : clock, synchronous active-high reset
//   bus        : regfile_writeback_if.slave (ALU result, load issue/response, decode checks, regfile write)
//   WB_FORWARD_EN : adds write-stage forwarding hits that mask the stall
module regfile_writeback #(
   parameter int LD_DEPTH = 4,
   parameter int DATA_W   = 32
) (
   input logic              clk,
   input logic              reset,
   regfile_writeback_if.slave bus
);
   localparam int AW = $clog2(LD_DEPTH);
   logic [4:0]        tags [LD_DEPTH];
   logic [AW-1:0]     wr_ptr, rd_ptr;
   logic [AW:0]       count;
   logic [31:0]       busy, busy_set, busy_clr;
   logic              full, empty, push, pop, ld_we, we_q;
   logic              rs_hit, rt_hit, rd_hit;
   logic [4:0]        head, addr_q;
   logic [DATA_W-1:0] data_q;
   always_comb begin
      full     = count == (AW+1)'(LD_DEPTH);
      empty    = count == '0;
      head     = tags[rd_ptr];
      push     = bus.ld_issue_valid && !full;
      pop      = bus.ld_resp_valid && !bus.alu_valid && !empty;
      busy_set = push && bus.ld_issue_rd != 5'd0 ? 32'd1 << bus.ld_issue_rd : 32'd0;
      busy_clr = ld_we ? 32'd1 << addr_q : 32'd0;
   end
`ifdef WB_FORWARD_EN
   always_comb begin
      rs_hit = we_q && addr_q != 5'd0 && addr_q == bus.chk_rs;
      rt_hit = we_q && addr_q != 5'd0 && addr_q == bus.chk_rt;
      rd_hit = we_q && addr_q == bus.chk_rd;
   end
   assign bus.fwd_rs_hit = rs_hit;
   assign bus.fwd_rt_hit = rt_hit;
`else
   assign rs_hit = 1'b0;
   assign rt_hit = 1'b0;
   assign rd_hit = 1'b0;
`endif
   assign bus.stall = (bus.chk_rs != 5'd0 && busy[bus.chk_rs] && !rs_hit) ||
                      (bus.chk_rt != 5'd0 && busy[bus.chk_rt] && !rt_hit) ||
                      (bus.chk_rd != 5'd0 && busy[bus.chk_rd] && !rd_hit);
   assign bus.ld_issue_ready = !full;
   assign bus.ld_resp_ready  = pop;
   assign bus.we             = we_q;
   assign bus.rd_addr        = addr_q;
   assign bus.rd_data        = data_q;
   // set is OR-ed after the clear so a re-issue to the register being written keeps it busy
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         busy   <= '0;
         we_q   <= 1'b0;
         ld_we  <= 1'b0;
         addr_q <= '0;
         data_q <= '0;
      end else begin
         wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
         rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
         count  <= count + (AW+1)'(push) - (AW+1)'(pop);
         busy   <= (busy & ~busy_clr) | busy_set;
         we_q   <= bus.alu_valid ? bus.alu_rd != 5'd0 : pop && head != 5'd0;
         ld_we  <= pop && head != 5'd0;
         if (bus.alu_valid || pop) begin
            addr_q <= bus.alu_valid ? bus.alu_rd : head;
            data_q <= bus.alu_valid ? bus.alu_data : bus.ld_resp_data;
         end
      end
   end
   always_ff @(posedge clk)
      if (push) tags[wr_ptr] <= bus.ld_issue_rd;
endmodule

// File: tb/tb_regfile_writeback.sv
// tb_regfile_writeback: vector table, corner sequences and random run against a queue-based model
module tb_regfile_writeback;
   localparam int DEPTH = 4;
`ifdef WB_FORWARD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;
   regfile_writeback_if #(.DATA_W(32)) bus();
   regfile_writeback #(.LD_DEPTH(DEPTH), .DATA_W(32)) dut (.clk(clk), .reset(reset), .bus(bus));
   typedef struct {
      bit av; bit [4:0] ard; bit [31:0] adata;
      bit iv; bit [4:0] ird;
      bit rv; bit [31:0] rdata;
      bit [4:0] rs, rt, rdc;
      bit e_ir, e_rr, e_st, e_we; bit [4:0] e_addr; bit [31:0] e_data;
   } vec_t;
   int checks = 0;
   int errors = 0;
   int q[$];
   bit [31:0] mbusy;
   bit mwe;
   bit [4:0] maddr;
   bit [31:0] mdata;
   int mclr;
   logic o_ir, o_rr, o_st, o_we;
   logic [4:0] o_addr;
   logic [31:0] o_data;
   vec_t tbl[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(bit av, bit [4:0] ard, bit [31:0] adata, bit iv, bit [4:0] ird,
                               bit rv, bit [31:0] rdata, bit [4:0] rs, bit [4:0] rt, bit [4:0] rdc,
                               bit eir, bit err, bit est, bit ewe, bit [4:0] ea, bit [31:0] ed);
      vec_t v;
      v.av = av; v.ard = ard; v.adata = adata; v.iv = iv; v.ird = ird; v.rv = rv; v.rdata = rdata;
      v.rs = rs; v.rt = rt; v.rdc = rdc;
      v.e_ir = eir; v.e_rr = err; v.e_st = est; v.e_we = ewe; v.e_addr = ea; v.e_data = ed;
      return v;
   endfunction

   function automatic vec_t idle(bit [4:0] rs, bit [4:0] rt, bit [4:0] rdc);
      return mk(0, 0, 0, 0, 0, 0, 0, rs, rt, rdc, 0, 0, 0, 0, 0, 0);
   endfunction

   function automatic bit hit(bit [4:0] r);
      return FWD && mwe && r != 0 && maddr == r;
   endfunction

   function automatic bit mstall(bit [4:0] rs, bit [4:0] rt, bit [4:0] rdc);
      return (rs != 0 && mbusy[rs] && !hit(rs)) || (rt != 0 && mbusy[rt] && !hit(rt)) ||
             (rdc != 0 && mbusy[rdc] && !hit(rdc));
   endfunction

   task automatic model_reset();
      q.delete();
      mbusy = 0; mwe = 0; maddr = 0; mdata = 0; mclr = -1;
   endtask

   task automatic do_reset();
      bus.alu_valid = 0; bus.alu_rd = 0; bus.alu_data = 0;
      bus.ld_issue_valid = 0; bus.ld_issue_rd = 0;
      bus.ld_resp_valid = 0; bus.ld_resp_data = 0;
      bus.chk_rs = 0; bus.chk_rt = 0; bus.chk_rd = 0;
      reset = 1;
      @(posedge clk);
      #1;
      reset = 0;
      model_reset();
   endtask

   // one clock: drive, compare combinational outputs, advance model, compare registered write
   task automatic apply(input vec_t v);
      bit push, pop;
      int tag;
      bus.alu_valid = v.av; bus.alu_rd = v.ard; bus.alu_data = v.adata;
      bus.ld_issue_valid = v.iv; bus.ld_issue_rd = v.ird;
      bus.ld_resp_valid = v.rv; bus.ld_resp_data = v.rdata;
      bus.chk_rs = v.rs; bus.chk_rt = v.rt; bus.chk_rd = v.rdc;
      #1;
      o_ir = bus.ld_issue_ready; o_rr = bus.ld_resp_ready; o_st = bus.stall;
      push = v.iv && q.size() < DEPTH;
      pop  = v.rv && !v.av && q.size() != 0;
      chk("model ld_issue_ready", o_ir, 32'(q.size() < DEPTH));
      chk("model ld_resp_ready", o_rr, 32'(pop));
      chk("model stall", o_st, 32'(mstall(v.rs, v.rt, v.rdc)));
`ifdef WB_FORWARD_EN
      chk("model fwd_rs_hit", bus.fwd_rs_hit, 32'(hit(v.rs)));
      chk("model fwd_rt_hit", bus.fwd_rt_hit, 32'(hit(v.rt)));
`endif
      if (mclr > 0) mbusy[mclr] = 0;
      tag = pop ? q.pop_front() : 0;
      if (push) begin
         q.push_back(int'(v.ird));
         if (v.ird != 0) mbusy[v.ird] = 1;
      end
      mclr = -1;
      if (v.av) begin
         mwe = v.ard != 0; maddr = v.ard; mdata = v.adata;
      end else if (pop) begin
         mwe = tag != 0; maddr = tag[4:0]; mdata = v.rdata;
         mclr = tag != 0 ? tag : -1;
      end else mwe = 0;
      @(posedge clk);
      #1;
      o_we = bus.we; o_addr = bus.rd_addr; o_data = bus.rd_data;
      chk("model we", o_we, 32'(mwe));
      chk("model rd_addr", o_addr, 32'(maddr));
      chk("model rd_data", o_data, mdata);
   endtask

   initial begin
      vec_t v;
      for (int i = 0; i < 3; i++) tbl.push_back(mk(0,0,0, 0,0, 0,0, 0,0,0, 1,0,0, 0,0,0));
      tbl.push_back(mk(1,3,32'hDEADBEEF, 0,0, 0,0, 0,0,0, 1,0,0, 1,3,32'hDEADBEEF));
      tbl.push_back(mk(1,0,32'h55, 0,0, 0,0, 0,0,0, 1,0,0, 0,0,32'h55));
      tbl.push_back(mk(0,0,0, 0,0, 0,0, 0,0,0, 1,0,0, 0,0,32'h55));
      tbl.push_back(mk(0,0,0, 1,5, 0,0, 5,0,0, 1,0,0, 0,0,32'h55));
      tbl.push_back(mk(0,0,0, 0,0, 0,0, 5,0,0, 1,0,1, 0,0,32'h55));
      tbl.push_back(mk(0,0,0, 0,0, 1,32'h12345678, 5,0,0, 1,1,1, 1,5,32'h12345678));
      tbl.push_back(mk(0,0,0, 0,0, 0,0, 5,0,0, 1,0,!FWD, 0,5,32'h12345678));
      tbl.push_back(mk(0,0,0, 0,0, 0,0, 5,0,0, 1,0,0, 0,5,32'h12345678));
      tbl.push_back(mk(0,0,0, 1,12, 0,0, 0,0,0, 1,0,0, 0,5,32'h12345678));
      tbl.push_back(mk(1,7,32'h1, 0,0, 1,32'hA5A5A5A5, 0,0,0, 1,0,0, 1,7,32'h1));
      tbl.push_back(mk(0,0,0, 0,0, 1,32'hA5A5A5A5, 0,0,0, 1,1,0, 1,12,32'hA5A5A5A5));
      tbl.push_back(mk(0,0,0, 0,0, 0,0, 0,12,0, 1,0,!FWD, 0,12,32'hA5A5A5A5));
      tbl.push_back(mk(0,0,0, 0,0, 1,32'hFFFFFFFF, 0,12,0, 1,0,0, 0,12,32'hA5A5A5A5));
      for (int i = 8; i < 12; i++) tbl.push_back(mk(0,0,0, 1,5'(i), 0,0, 0,0,0, 1,0,0, 0,12,32'hA5A5A5A5));
      tbl.push_back(mk(0,0,0, 1,13, 0,0, 0,11,8, 0,0,1, 0,12,32'hA5A5A5A5));
      tbl.push_back(mk(0,0,0, 0,0, 1,32'h80, 13,0,0, 0,1,0, 1,8,32'h80));
      tbl.push_back(mk(0,0,0, 0,0, 1,32'h90, 0,0,8, 1,1,!FWD, 1,9,32'h90));
      tbl.push_back(mk(0,0,0, 0,0, 1,32'hA0, 8,0,0, 1,1,0, 1,10,32'hA0));
      tbl.push_back(mk(0,0,0, 0,0, 1,32'hB0, 0,0,0, 1,1,0, 1,11,32'hB0));
      tbl.push_back(mk(0,0,0, 0,0, 0,0, 9,10,11, 1,0,!FWD, 0,11,32'hB0));
      tbl.push_back(mk(0,0,0, 0,0, 0,0, 9,10,11, 1,0,0, 0,11,32'hB0));
      for (int i = 16; i < 20; i++) tbl.push_back(mk(0,0,0, 1,5'(i), 0,0, 0,0,0, 1,0,0, 0,11,32'hB0));
      tbl.push_back(mk(0,0,0, 0,0, 1,32'h100, 0,0,0, 0,1,0, 1,16,32'h100));
      for (int i = 1; i < 4; i++) tbl.push_back(mk(0,0,0, 0,0, 1,32'h100 + i, 0,0,0, 1,1,0, 1,5'(16 + i),32'h100 + i));
      tbl.push_back(mk(0,0,0, 0,0, 0,0, 19,0,0, 1,0,!FWD, 0,19,32'h103));
      tbl.push_back(mk(0,0,0, 0,0, 0,0, 19,0,0, 1,0,0, 0,19,32'h103));
      tbl.push_back(mk(0,0,0, 1,0, 0,0, 0,0,0, 1,0,0, 0,19,32'h103));
      tbl.push_back(mk(0,0,0, 0,0, 1,32'h77, 0,0,0, 1,1,0, 0,0,32'h77));
      tbl.push_back(mk(0,0,0, 0,0, 0,0, 0,0,0, 1,0,0, 0,0,32'h77));

      do_reset();
      chk("reset we", bus.we, 0);
      chk("reset rd_addr", bus.rd_addr, 0);
      chk("reset rd_data", bus.rd_data, 0);
      chk("reset stall", bus.stall, 0);
      chk("reset ld_issue_ready", bus.ld_issue_ready, 1);

      foreach (tbl[i]) begin
         apply(tbl[i]);
         chk($sformatf("vec%0d ld_issue_ready", i), o_ir, 32'(tbl[i].e_ir));
         chk($sformatf("vec%0d ld_resp_ready", i), o_rr, 32'(tbl[i].e_rr));
         chk($sformatf("vec%0d stall", i), o_st, 32'(tbl[i].e_st));
         chk($sformatf("vec%0d we", i), o_we, 32'(tbl[i].e_we));
         chk($sformatf("vec%0d rd_addr", i), o_addr, 32'(tbl[i].e_addr));
         chk($sformatf("vec%0d rd_data", i), o_data, tbl[i].e_data);
      end

      // reissue to the register whose load is being written: busy must survive
      apply(mk(0,0,0, 1,20, 0,0, 0,0,0, 0,0,0, 0,0,0));
      apply(mk(0,0,0, 0,0, 1,32'hCAFE, 0,0,0, 0,0,0, 0,0,0));
      apply(mk(0,0,0, 1,20, 0,0, 20,0,0, 0,0,0, 0,0,0));
      chk("setwin write stall", o_st, 32'(!FWD));
      apply(idle(20, 0, 0));
      chk("setwin stall kept", o_st, 1);
      apply(mk(0,0,0, 0,0, 1,32'hBEEF, 0,0,0, 0,0,0, 0,0,0));
      chk("setwin second write", o_addr, 20);
      apply(idle(0, 0, 0));
      apply(idle(20, 0, 0));
      chk("setwin stall cleared", o_st, 0);

      // ALU write to a busy register is written but leaves busy set
      apply(mk(0,0,0, 1,21, 0,0, 0,0,0, 0,0,0, 0,0,0));
      apply(mk(1,21,32'h42, 0,0, 0,0, 0,0,0, 0,0,0, 0,0,0));
      chk("alu busy we", o_we, 1);
      chk("alu busy data", o_data, 32'h42);
      apply(idle(0, 21, 0));
      apply(idle(0, 21, 0));
      chk("alu busy stall kept", o_st, 1);

      // reset with a load in flight drops the tag and the busy bit
      apply(mk(0,0,0, 1,6, 0,0, 0,0,0, 0,0,0, 0,0,0));
      apply(idle(6, 0, 0));
      chk("pre-reset stall", o_st, 1);
      do_reset();
      chk("midreset we", bus.we, 0);
      chk("midreset rd_addr", bus.rd_addr, 0);
      apply(mk(0,0,0, 0,0, 1,32'h99, 6,21,6, 0,0,0, 0,0,0));
      chk("midreset stall", o_st, 0);
      chk("midreset ld_resp_ready", o_rr, 0);
      chk("midreset ld_issue_ready", o_ir, 1);
      chk("midreset no write", o_we, 0);

      do_reset();
      for (int n = 0; n < 3000; n++) begin
         v.av = $urandom_range(0, 9) < 3; v.ard = 5'($urandom_range(0, 7)); v.adata = $urandom;
         v.iv = $urandom_range(0, 9) < 4; v.ird = 5'($urandom_range(0, 7));
         v.rv = $urandom_range(0, 9) < 5; v.rdata = $urandom;
         v.rs = 5'($urandom_range(0, 7)); v.rt = 5'($urandom_range(0, 7)); v.rdc = 5'($urandom_range(0, 7));
         if (n % 500 == 499) do_reset();
         else apply(v);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/regfile_writeback.md
Name: regfile_writeback

Overview:
- Single write-port arbiter and scoreboard sitting in front of the 32x32 register file write port (we / rd_addr / rd_data).
- Merges single-cycle ALU results and in-order multi-cycle load responses into one registered write per cycle.
- Tracks destination registers with loads in flight so the decode stage can stall on RAW/WAW hazards.

Parameters:
- LD_DEPTH, 4, load tag FIFO entries (power of 2, >=2)
- DATA_W, 32, write data width

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous active-high reset
- alu_valid  input  1  ALU result valid this cycle (cannot be back-pressured)
- alu_rd  input  5  ALU destination register
- alu_data  input  DATA_W  ALU result
- ld_issue_valid  input  1  load issued, destination ld_issue_rd
- ld_issue_rd  input  5  load destination register
- ld_issue_ready  output  1  tag FIFO not full
- ld_resp_valid  input  1  load data returned (in issue order)
- ld_resp_data  input  DATA_W  load data
- ld_resp_ready  output  1  response accepted this cycle
- chk_rs  input  5  decode-stage source 1
- chk_rt  input  5  decode-stage source 2
- chk_rd  input  5  decode-stage destination
- stall  output  1  hazard on a pending load destination
- we  output  1  regfile write enable
- rd_addr  output  5  regfile write address
- rd_data  output  DATA_W  regfile write data

Behaviour:
- All state is on posedge clk. reset is synchronous and active-high: busy[31:0]=0, tag FIFO empty, we=0, rd_addr=0, rd_data=0. A reset asserted mid-operation discards all pending tags and busy bits.
- Issue: the handshake completes when ld_issue_valid && ld_issue_ready.
  - Pushes ld_issue_rd into the tag FIFO.
  - Sets busy[ld_issue_rd] next cycle, unless rd is 0.
  - ld_issue_ready = !full.
- Response acceptance: ld_resp_ready = ld_resp_valid && !alu_valid && !fifo_empty. ALU has fixed priority.
  - An accepted response pops the FIFO head tag.
  - A response arriving with an empty FIFO is never accepted.
- Write stage (latency 1):
  - The cycle after an ALU result or accepted response: we=1, rd_addr=tag/alu_rd, rd_data=data.
  - With no source that cycle, we=0 and rd_addr/rd_data hold their previous values.
  - Writes to r0 drive we=0 (address and data still registered).
- Busy clear: busy[rd_addr] clears at the clock edge ending the cycle in which a load write has we=1. ALU writes never clear busy.
- Same-cycle set and clear of the same register: set wins.
- Same-cycle push and pop: count unchanged. Push when full is blocked by ld_issue_ready=0.
- stall is combinational and asserts when any of the following holds:
  - (chk_rs!=0 && busy[chk_rs])
  - (chk_rt!=0 && busy[chk_rt])
  - (chk_rd!=0 && busy[chk_rd])
- An ALU write to a busy register is a protocol violation upstream. It is written as-is and busy is unchanged.
- The FIFO pointers are log2(LD_DEPTH) bits and wrap modulo depth. count is log2(LD_DEPTH)+1 bits.

Optional Feature:
- Macro WB_FORWARD_EN.
- When defined:
  - Adds outputs fwd_rs_hit and fwd_rt_hit (1 bit each). Each is high when we=1 && rd_addr!=0 && rd_addr==chk_rs (resp. chk_rt).
  - stall ignores the busy bit of a register whose hit is high. Decode muxes rd_data in place of regfile data.
  - The chk_rd busy check is also masked when rd_addr==chk_rd && we=1.
- When undefined: no fwd ports, and stall uses the busy bits only. A consumer therefore stalls through the write cycle and reads the regfile one cycle later.

Test Plan:
- Reset, then idle 3 cycles -> we=0, rd_addr=0, rd_data=0, stall=0, ld_issue_ready=1.
- ALU write alu_rd=3, alu_data=0xDEADBEEF -> next cycle we=1, rd_addr=3, rd_data=0xDEADBEEF.
- alu_rd=0 -> we stays 0.
- Issue load rd=5. Set chk_rs=5 -> stall=1. Response 0x12345678 two cycles later -> we=1, rd_addr=5. stall=0 the cycle after the write.
- Same cycle: alu_valid (rd=7, 0x1) and ld_resp_valid -> ld_resp_ready=0. Next cycle, with alu_valid low -> response accepted and written.
- Issue 4 loads (rd=8,9,10,11) -> ld_issue_ready=0. A 5th issue is ignored. Four responses -> writes in order 8,9,10,11 and all busy bits clear. Repeat to exercise pointer wrap.
- Issue load rd=6, then reset before the response -> busy clear, FIFO empty, stall=0. A later ld_resp_valid gives ld_resp_ready=0.
- WB_FORWARD_EN build: during the we cycle for rd=5 with chk_rs=5 -> fwd_rs_hit=1, stall=0.
